// File: rtl/pe_seq_ctrl.sv
// Job sequencer for a systolic PE: streams weights then activations into the PE
// scratchpad, fires the compute, waits for completion and drains the sums.
module pe_seq_ctrl #(
   parameter int dataSize      = 8,
   parameter int rfNumRegister = 16,
   parameter int TIMEOUT       = 1024
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                cfg_start,
   input  logic [7:0]          cfg_wcount,
   input  logic [7:0]          cfg_acount,
   input  logic                abort,
   input  logic                w_valid,
   input  logic [dataSize-1:0] w_data,
   output logic                w_ready,
   input  logic                a_valid,
   input  logic [dataSize-1:0] a_data,
   output logic                a_ready,
   output logic                pe_loadw,
   output logic                pe_loada,
   output logic                pe_start,
   output logic                pe_sums,
   output logic [dataSize-1:0] pe_weights,
   output logic [dataSize-1:0] pe_acts,
   output logic [7:0]          pe_wcount,
   output logic [7:0]          pe_acount,
   input  logic                pe_done,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [2:0]          dbg_state
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOADW   = 3'd1;
   localparam logic [2:0] S_LOADA   = 3'd2;
   localparam logic [2:0] S_SETTLE  = 3'd3;
   localparam logic [2:0] S_START   = 3'd4;
   localparam logic [2:0] S_COMPUTE = 3'd5;
   localparam logic [2:0] S_SUMS    = 3'd6;
   localparam logic [2:0] S_FINISH  = 3'd7;

   localparam int TW = $clog2(TIMEOUT + 1);

   // Stream handshake: a beat transfers on any cycle where valid and ready are
   // both high; ready is a pure function of state and never depends on valid.
   logic [2:0]    state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [7:0]    wcount_q, acount_q;
   logic          error_q, error_d;
   logic          cfg_ok;

   assign cfg_ok = (cfg_wcount != 8'd0) && (cfg_wcount <= cfg_acount) &&
                   (int'(cfg_acount) <= rfNumRegister);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      error_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            tmr_d = '0;
            if (cfg_start) begin
               if (cfg_ok) state_d = S_LOADW;
               else        error_d = 1'b1;
            end
         end
         // A valid gap restarts the phase because the PE resets its write address
         // whenever its load strobe drops.
         S_LOADW: begin
            if (!w_valid)                         cnt_d = 8'd0;
            else if (cnt_q == wcount_q - 8'd1) begin
               cnt_d   = 8'd0;
               state_d = S_LOADA;
            end else                              cnt_d = cnt_q + 8'd1;
         end
         S_LOADA: begin
            if (!a_valid)                         cnt_d = 8'd0;
            else if (cnt_q == acount_q - 8'd1) begin
               cnt_d   = 8'd0;
               state_d = S_SETTLE;
            end else                              cnt_d = cnt_q + 8'd1;
         end
         S_SETTLE: state_d = S_START;
         S_START: begin
            state_d = S_COMPUTE;
            tmr_d   = '0;
         end
         S_COMPUTE: begin
            if (pe_done) begin
               state_d = S_SUMS;
               cnt_d   = 8'd0;
            end else if (tmr_q == TW'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               error_d = 1'b1;
            end else tmr_d = tmr_q + TW'(1);
         end
         // Sum count is acount-wcount+1, so the last sum index is acount-wcount.
         S_SUMS: begin
            if (cnt_q == acount_q - wcount_q) begin
               state_d = S_FINISH;
               cnt_d   = 8'd0;
            end else cnt_d = cnt_q + 8'd1;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = 8'd0;
         tmr_d   = '0;
         error_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         tmr_q    <= '0;
         wcount_q <= 8'd0;
         acount_q <= 8'd0;
         error_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         error_q <= error_d;
         if (state_q == S_IDLE && cfg_start && cfg_ok) begin
            wcount_q <= cfg_wcount;
            acount_q <= cfg_acount;
         end
      end
   end

   assign w_ready    = (state_q == S_LOADW);
   assign a_ready    = (state_q == S_LOADA);
   assign pe_loadw   = w_ready && w_valid;
   assign pe_loada   = a_ready && a_valid;
   assign pe_weights = pe_loadw ? w_data : '0;
   assign pe_acts    = pe_loada ? a_data : '0;
   assign pe_start   = (state_q == S_START);
   assign pe_sums    = (state_q == S_SUMS);
   assign pe_wcount  = wcount_q;
   assign pe_acount  = acount_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_FINISH);
   assign error      = error_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: directed jobs push expected control-pulse events
// (kind, run length); a negedge monitor extracts runs from the DUT and pops/compares.
module tb_pe_seq_ctrl;

   localparam int K_LOADW = 1, K_LOADA = 2, K_START = 3, K_SUMS = 4, K_DONE = 5, K_ERROR = 6;

   logic       clk, nrst;
   logic       cfg_start, abort, w_valid, a_valid, pe_done;
   logic [7:0] cfg_wcount, cfg_acount, w_data, a_data;
   logic       w_ready, a_ready, pe_loadw, pe_loada, pe_start, pe_sums;
   logic [7:0] pe_weights, pe_acts, pe_wcount, pe_acount;
   logic       busy, done, error;
   logic [2:0] dbg_state;

   int tests = 0;
   int fails = 0;
   logic [15:0] exp_q[$];

   pe_seq_ctrl dut (
      .clk(clk), .nrst(nrst), .cfg_start(cfg_start), .cfg_wcount(cfg_wcount),
      .cfg_acount(cfg_acount), .abort(abort), .w_valid(w_valid), .w_data(w_data),
      .w_ready(w_ready), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .pe_loadw(pe_loadw), .pe_loada(pe_loada), .pe_start(pe_start), .pe_sums(pe_sums),
      .pe_weights(pe_weights), .pe_acts(pe_acts), .pe_wcount(pe_wcount),
      .pe_acount(pe_acount), .pe_done(pe_done), .busy(busy), .done(done),
      .error(error), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input int len);
      exp_q.push_back({8'(kind), 8'(len)});
   endtask

   function automatic logic sig_val(input int kind);
      case (kind)
         K_LOADW: return pe_loadw;
         K_LOADA: return pe_loada;
         K_START: return pe_start;
         K_SUMS:  return pe_sums;
         K_DONE:  return done;
         default: return error;
      endcase
   endfunction

   // monitor / scoreboard
   int cyc = 0;
   int last_la = -100;
   int run[6];
   logic prev_start = 1'b0;

   task automatic got_event(input int kind, input int len);
      logic [15:0] ev, exp;
      ev = {8'(kind), 8'(len)};
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL event: got unexpected kind %0d len %0d, expected none", kind, len);
      end else begin
         exp = exp_q.pop_front();
         if (ev != exp) begin
            fails++;
            $display("FAIL event: got kind %0d len %0d, expected kind %0d len %0d",
                     kind, len, exp[15:8], exp[7:0]);
         end
      end
   endtask

   always @(negedge clk) begin
      logic [5:0] cur;
      cyc++;
      cur = {error, done, pe_sums, pe_start, pe_loada, pe_loadw};
      for (int k = 0; k < 6; k++) begin
         if (cur[k]) run[k]++;
         else if (run[k] > 0) begin
            got_event(k + 1, run[k]);
            run[k] = 0;
         end
      end
      if (cur[3:0] != 4'd0) chk("pe_ctrl_onehot", $countones(cur[3:0]), 1);
      if (pe_loadw) chk("pe_weights", int'(pe_weights), int'(w_data));
      if (pe_loada) chk("pe_acts", int'(pe_acts), int'(a_data));
      if (pe_start && !prev_start) chk("settle_gap", cyc - last_la, 2);
      if (pe_loada) last_la = cyc;
      prev_start = pe_start;
   end

   // driver tasks
   task automatic wait_for(input int kind, input int max_cyc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sig_val(kind) && n < max_cyc);
      if (!sig_val(kind)) begin
         tests++;
         fails++;
         $display("FAIL wait_kind_%0d: got timeout after %0d cycles, expected assertion", kind, n);
      end
   endtask

   task automatic start_job(input logic [7:0] w, input logic [7:0] a);
      @(posedge clk); #1;
      cfg_wcount = w;
      cfg_acount = a;
      cfg_start  = 1'b1;
      @(posedge clk); #1;
      cfg_start  = 1'b0;
      abort      = 1'b0;
   endtask

   task automatic answer_done(input int delay);
      wait_for(K_START, 100);
      repeat (delay) @(posedge clk);
      #1 pe_done = 1'b1;
      @(posedge clk); #1 pe_done = 1'b0;
   endtask

   task automatic all_zero(input string name);
      chk(name, int'({w_ready, a_ready, pe_loadw, pe_loada, pe_start, pe_sums,
                      busy, done, error}), 0);
      chk({name, "_data"}, int'({pe_weights, pe_acts, pe_wcount, pe_acount}), 0);
   endtask

   initial begin
      int n;
      nrst = 1'b0; cfg_start = 1'b0; abort = 1'b0; pe_done = 1'b0;
      cfg_wcount = 8'd0; cfg_acount = 8'd0;
      w_valid = 1'b1; a_valid = 1'b1; w_data = 8'hA5; a_data = 8'h3C;
      #3 all_zero("reset");
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;

      // normal job 3/5 with a cfg_start while busy that must be ignored
      push(K_LOADW, 3); push(K_LOADA, 5); push(K_START, 1); push(K_SUMS, 3); push(K_DONE, 1);
      start_job(8'd3, 8'd5);
      chk("busy_loadw", int'(busy), 1);
      wait_for(K_LOADA, 20);
      cfg_wcount = 8'd6; cfg_acount = 8'd4; cfg_start = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
      answer_done(10);
      wait_for(K_DONE, 50);
      chk("pe_wcount", int'(pe_wcount), 3);
      chk("pe_acount", int'(pe_acount), 5);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);

      // illegal config: wcount > acount
      push(K_ERROR, 1);
      start_job(8'd6, 8'd4);
      repeat (3) begin
         @(negedge clk);
         chk("busy_bad_cfg", int'(busy), 0);
      end

      // acount above rfNumRegister
      push(K_ERROR, 1);
      start_job(8'd1, 8'd17);
      repeat (3) @(negedge clk);

      // valid gap after two beats restarts the weight phase
      push(K_LOADW, 2); push(K_LOADW, 4); push(K_LOADA, 4); push(K_START, 1);
      push(K_SUMS, 1); push(K_DONE, 1);
      start_job(8'd4, 8'd4);
      wait_for(K_LOADW, 20);
      @(posedge clk);
      @(posedge clk); #1 w_valid = 1'b0;
      @(posedge clk); #1 w_valid = 1'b1;
      answer_done(3);
      wait_for(K_DONE, 50);

      // timeout: pe_done never comes
      push(K_LOADW, 1); push(K_LOADA, 1); push(K_START, 1); push(K_ERROR, 1);
      start_job(8'd1, 8'd1);
      wait_for(K_START, 20);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!error && n < 2000);
      chk("timeout_cycles", n, 1025);
      chk("busy_timeout", int'(busy), 0);

      // abort on second of three sum cycles
      push(K_LOADW, 3); push(K_LOADA, 5); push(K_START, 1); push(K_SUMS, 2);
      start_job(8'd3, 8'd5);
      answer_done(4);
      wait_for(K_SUMS, 20);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_sums", int'(pe_sums), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_error", int'(error), 0);
      repeat (5) @(negedge clk);

      // asynchronous reset in the middle of LOADA
      push(K_LOADW, 3); push(K_LOADA, 2);
      start_job(8'd3, 8'd5);
      wait_for(K_LOADA, 20);
      @(negedge clk);
      #1 nrst = 1'b0;
      #1 all_zero("mid_reset");
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;

      // fresh job after reset, with abort held in IDLE (ignored)
      push(K_LOADW, 2); push(K_LOADA, 2); push(K_START, 1); push(K_SUMS, 1); push(K_DONE, 1);
      abort = 1'b1;
      start_job(8'd2, 8'd2);
      answer_done(2);
      wait_for(K_DONE, 50);
      chk("pe_wcount_2", int'(pe_wcount), 2);

      repeat (5) @(negedge clk);
      chk("exp_q_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
